id_stage_pipe: RTL and testbench

- Registered, flow-controlled RV32I decode stage; the successor to the combinational decoder.
- Sits between IF and EX with valid/ready handshakes on both sides and a 2-entry skid buffer, so back-pressure does not create a combinational ready path.
- Decodes the full RV32I base integer set (no FENCE/SYSTEM) and flags illegal encodings.
- Raises a one-cycle early JAL redirect to IF with the computed target.

---
 rtl/id_stage_pipe.sv | 251 +++++++++++++++++++++++++
 tb/tb_id_stage_pipe.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/id_stage_pipe.sv
// id_stage_pipe: registered RV32I decode stage with valid/ready on both sides,
// a 2-entry skid buffer (or single register) and an early JAL redirect to IF.

// Fallback instruction-ID codes, used when defines.v is not compiled ahead of this file.
`ifndef InstIDDepth
`define InstIDDepth 6
`endif
`ifndef ID_LUI
`define ID_LUI   1
`define ID_AUIPC 2
`define ID_JAL   3
`define ID_JALR  4
`define ID_BEQ   5
`define ID_BNE   6
`define ID_BLT   7
`define ID_BGE   8
`define ID_BLTU  9
`define ID_BGEU  10
`define ID_LB    11
`define ID_LH    12
`define ID_LW    13
`define ID_LBU   14
`define ID_LHU   15
`define ID_SB    16
`define ID_SH    17
`define ID_SW    18
`define ID_ADDI  19
`define ID_SLTI  20
`define ID_SLTIU 21
`define ID_XORI  22
`define ID_ORI   23
`define ID_ANDI  24
`define ID_SLLI  25
`define ID_SRLI  26
`define ID_SRAI  27
`define ID_ADD   28
`define ID_SUB   29
`define ID_SLL   30
`define ID_SLT   31
`define ID_SLTU  32
`define ID_XOR   33
`define ID_SRL   34
`define ID_SRA   35
`define ID_OR    36
`define ID_AND   37
`endif

module id_stage_pipe #(
  parameter int PC_W    = 32,
  parameter int ID_W    = `InstIDDepth,
  parameter bit SKID_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_vld,
  output logic            in_rdy,
  input  logic [31:0]     in_inst,
  input  logic [PC_W-1:0] in_pc,
  output logic            out_vld,
  input  logic            out_rdy,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [4:0]      out_rd,
  output logic [31:0]     out_imm,
  output logic [ID_W-1:0] out_instID,
  output logic [PC_W-1:0] out_pc,
  output logic            out_illegal,
  output logic            jmp_vld,
  output logic [PC_W-1:0] jmp_addr
);

  typedef struct packed {
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [31:0]     imm;
    logic [ID_W-1:0] id;
    logic [PC_W-1:0] pc;
    logic            ill;
  } ent_t;

  ent_t main_q, main_d, skid_q, skid_d, dec;
  logic main_vld_q, main_vld_d, skid_vld_q, skid_vld_d;
  logic in_xfer, out_xfer;

  logic [6:0]      opc;
  logic [2:0]      f3;
  logic [6:0]      f7;
  logic [31:0]     imm_i, imm_s, imm_b, imm_u, imm_j, imm_v;
  logic [ID_W-1:0] id_v;
  logic            is_jal;

  assign opc = in_inst[6:0];
  assign f3  = in_inst[14:12];
  assign f7  = in_inst[31:25];

  assign imm_i = {{20{in_inst[31]}}, in_inst[31:20]};
  assign imm_s = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
  assign imm_b = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
  assign imm_u = {in_inst[31:12], 12'b0};
  assign imm_j = {{12{in_inst[31]}}, in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};

  // Instruction decode: anything not matched leaves id_v at 0 and is flagged illegal.
  always_comb begin
    id_v   = '0;
    imm_v  = '0;
    is_jal = 1'b0;
    case (opc)
      7'h37: begin id_v = ID_W'(`ID_LUI);   imm_v = imm_u; end
      7'h17: begin id_v = ID_W'(`ID_AUIPC); imm_v = imm_u; end
      7'h6F: begin id_v = ID_W'(`ID_JAL);   imm_v = imm_j; is_jal = 1'b1; end
      7'h67: if (f3 == 3'd0) begin id_v = ID_W'(`ID_JALR); imm_v = imm_i; end
      7'h63: begin
        imm_v = imm_b;
        case (f3)
          3'd0: id_v = ID_W'(`ID_BEQ);
          3'd1: id_v = ID_W'(`ID_BNE);
          3'd4: id_v = ID_W'(`ID_BLT);
          3'd5: id_v = ID_W'(`ID_BGE);
          3'd6: id_v = ID_W'(`ID_BLTU);
          3'd7: id_v = ID_W'(`ID_BGEU);
          default: ;
        endcase
      end
      7'h03: begin
        imm_v = imm_i;
        case (f3)
          3'd0: id_v = ID_W'(`ID_LB);
          3'd1: id_v = ID_W'(`ID_LH);
          3'd2: id_v = ID_W'(`ID_LW);
          3'd4: id_v = ID_W'(`ID_LBU);
          3'd5: id_v = ID_W'(`ID_LHU);
          default: ;
        endcase
      end
      7'h23: begin
        imm_v = imm_s;
        case (f3)
          3'd0: id_v = ID_W'(`ID_SB);
          3'd1: id_v = ID_W'(`ID_SH);
          3'd2: id_v = ID_W'(`ID_SW);
          default: ;
        endcase
      end
      7'h13: begin
        imm_v = imm_i;
        case (f3)
          3'd0: id_v = ID_W'(`ID_ADDI);
          3'd2: id_v = ID_W'(`ID_SLTI);
          3'd3: id_v = ID_W'(`ID_SLTIU);
          3'd4: id_v = ID_W'(`ID_XORI);
          3'd6: id_v = ID_W'(`ID_ORI);
          3'd7: id_v = ID_W'(`ID_ANDI);
          3'd1: if (f7 == 7'h00) id_v = ID_W'(`ID_SLLI);
          3'd5: if (f7 == 7'h00) id_v = ID_W'(`ID_SRLI);
                else if (f7 == 7'h20) id_v = ID_W'(`ID_SRAI);
          default: ;
        endcase
      end
      7'h33: begin
        if (f7 == 7'h00) begin
          case (f3)
            3'd0: id_v = ID_W'(`ID_ADD);
            3'd1: id_v = ID_W'(`ID_SLL);
            3'd2: id_v = ID_W'(`ID_SLT);
            3'd3: id_v = ID_W'(`ID_SLTU);
            3'd4: id_v = ID_W'(`ID_XOR);
            3'd5: id_v = ID_W'(`ID_SRL);
            3'd6: id_v = ID_W'(`ID_OR);
            default: id_v = ID_W'(`ID_AND);
          endcase
        end else if (f7 == 7'h20) begin
          if (f3 == 3'd0) id_v = ID_W'(`ID_SUB);
          else if (f3 == 3'd5) id_v = ID_W'(`ID_SRA);
        end
      end
      default: ;
    endcase
    if (id_v == '0) imm_v = '0;
  end

  // Pack the decoded fields into one entry.
  always_comb begin
    dec     = '0;
    dec.rs1 = in_inst[19:15];
    dec.rs2 = in_inst[24:20];
    dec.rd  = in_inst[11:7];
    dec.imm = imm_v;
    dec.id  = id_v;
    dec.pc  = in_pc;
    dec.ill = (id_v == '0);
  end

  // in_rdy comes straight from the skid flop, so EX back-pressure never reaches IF combinationally.
  assign in_rdy   = SKID_EN ? !skid_vld_q : (!main_vld_q || out_rdy);
  assign in_xfer  = in_vld && in_rdy;
  assign out_xfer = main_vld_q && out_rdy;

  assign jmp_vld  = in_xfer && !flush && is_jal;
  assign jmp_addr = jmp_vld ? (in_pc + PC_W'($signed(imm_j))) : '0;

  // Occupancy update: skid refills main when it drains; otherwise new data lands in the free slot.
  always_comb begin
    main_d     = main_q;
    skid_d     = skid_q;
    main_vld_d = main_vld_q;
    skid_vld_d = skid_vld_q;
    if (flush) begin
      main_vld_d = 1'b0;
      skid_vld_d = 1'b0;
    end else if (!main_vld_q || out_xfer) begin
      if (skid_vld_q) begin
        main_d     = skid_q;
        main_vld_d = 1'b1;
        skid_vld_d = 1'b0;
      end else begin
        main_vld_d = in_xfer;
        if (in_xfer) main_d = dec;
      end
    end else if (in_xfer) begin
      skid_d     = dec;
      skid_vld_d = 1'b1;
    end
  end

  // Entry registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      main_q     <= '0;
      skid_q     <= '0;
      main_vld_q <= 1'b0;
      skid_vld_q <= 1'b0;
    end else begin
      main_q     <= main_d;
      skid_q     <= skid_d;
      main_vld_q <= main_vld_d;
      skid_vld_q <= skid_vld_d;
    end
  end

  assign out_vld     = main_vld_q;
  assign out_rs1     = main_q.rs1;
  assign out_rs2     = main_q.rs2;
  assign out_rd      = main_q.rd;
  assign out_imm     = main_q.imm;
  assign out_instID  = main_q.id;
  assign out_pc      = main_q.pc;
  assign out_illegal = main_q.ill;

endmodule

// File: tb/tb_id_stage_pipe.sv
// Bench for id_stage_pipe: vector table with hand-derived decode results,
// scoreboard queue checked at the output handshake, plus stall/flush/reset sequences.
`timescale 1ns/1ps

module tb_id_stage_pipe;
  localparam int PC_W = 32;
  localparam int ID_W = 6;

  logic            clk = 1'b0;
  logic            rst, flush, in_vld, in_rdy, out_vld, out_rdy, out_illegal, jmp_vld;
  logic [31:0]     in_inst, out_imm;
  logic [PC_W-1:0] in_pc, out_pc, jmp_addr;
  logic [4:0]      out_rs1, out_rs2, out_rd;
  logic [ID_W-1:0] out_instID;

  id_stage_pipe #(.PC_W(PC_W), .ID_W(ID_W), .SKID_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_vld(in_vld), .in_rdy(in_rdy),
    .in_inst(in_inst), .in_pc(in_pc), .out_vld(out_vld), .out_rdy(out_rdy),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd), .out_imm(out_imm),
    .out_instID(out_instID), .out_pc(out_pc), .out_illegal(out_illegal),
    .jmp_vld(jmp_vld), .jmp_addr(jmp_addr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    int          id;
    logic [31:0] imm;
    bit          ill;
    bit          jal;
    logic [31:0] jaddr;
  } vec_t;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    int          id;
    logic [31:0] imm;
    bit          ill;
  } exp_t;

  vec_t tv[20];
  exp_t sb[$];
  int   nvec = 0;
  int   nerr = 0;
  bit   rand_rdy = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Random EX back-pressure during the shuffled pass.
  always begin
    @(posedge clk); #1;
    if (rand_rdy) out_rdy = 1'($urandom_range(0, 1));
  end

  // Output side: pop the scoreboard on each output transfer and check held data while stalled.
  logic        hold_p = 1'b0;
  logic [4:0]  h_rs1, h_rs2, h_rd;
  logic [31:0] h_imm, h_pc;
  logic [ID_W-1:0] h_id;
  logic        h_ill;
  always @(negedge clk) begin
    if (hold_p && out_vld) begin
      nvec++;
      if ({out_rs1, out_rs2, out_rd, out_imm, out_pc, out_instID, out_illegal} !==
          {h_rs1, h_rs2, h_rd, h_imm, h_pc, h_id, h_ill}) begin
        nerr++;
        $display("FAIL stall_stable: got id=%0d imm=%h pc=%h want id=%0d imm=%h pc=%h",
                 out_instID, out_imm, out_pc, h_id, h_imm, h_pc);
      end
    end
    if (out_vld && out_rdy && !rst && !flush) begin
      nvec++;
      if (sb.size() == 0) begin
        nerr++;
        $display("FAIL unexpected_out: got id=%0d pc=%h want no output", out_instID, out_pc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (out_instID !== ID_W'(e.id) || out_imm !== e.imm || out_illegal !== e.ill ||
            out_pc !== e.pc || out_rs1 !== e.inst[19:15] || out_rs2 !== e.inst[24:20] ||
            out_rd !== e.inst[11:7]) begin
          nerr++;
          $display("FAIL out_entry: got id=%0d imm=%h ill=%b pc=%h rs1=%0d rs2=%0d rd=%0d want id=%0d imm=%h ill=%b pc=%h inst=%h",
                   out_instID, out_imm, out_illegal, out_pc, out_rs1, out_rs2, out_rd,
                   e.id, e.imm, e.ill, e.pc, e.inst);
        end
      end
    end
    hold_p = out_vld && !out_rdy && !flush && !rst;
    {h_rs1, h_rs2, h_rd, h_imm, h_pc, h_id, h_ill} =
      {out_rs1, out_rs2, out_rd, out_imm, out_pc, out_instID, out_illegal};
  end

  // Present one instruction until accepted; checks the JAL redirect in the accept cycle.
  task automatic send(input vec_t v);
    int  k;
    bit  acc;
    exp_t e;
    in_vld = 1'b1; in_inst = v.inst; in_pc = v.pc;
    acc = 1'b0; k = 0;
    while (!acc && k < 60) begin
      @(negedge clk);
      if (in_rdy) begin
        acc = 1'b1;
        chk("jmp_vld", 64'(jmp_vld), 64'(v.jal));
        chk("jmp_addr", 64'(jmp_addr), v.jal ? 64'(v.jaddr) : 64'd0);
        e.inst = v.inst; e.pc = v.pc; e.id = v.id; e.imm = v.imm; e.ill = v.ill;
        sb.push_back(e);
      end
      @(posedge clk); #1;
      k++;
    end
    in_vld = 1'b0;
    if (!acc) begin
      nvec++; nerr++;
      $display("FAIL accept_timeout: got in_rdy=0 for 60 cycles want 1 (inst %h)", v.inst);
    end
  endtask

  task automatic drain();
    int k = 0;
    while (sb.size() != 0 && k < 100) begin @(posedge clk); #1; k++; end
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    //     inst          pc            id  imm           ill jal jaddr
    tv[0]  = '{32'hFFF00093, 32'h100,  19, 32'hFFFFFFFF, 0, 0, 0}; // ADDI x1,x0,-1
    tv[1]  = '{32'h402081B3, 32'h104,  29, 32'h0,        0, 0, 0}; // SUB
    tv[2]  = '{32'h40335293, 32'h108,  27, 32'h403,      0, 0, 0}; // SRAI x5,x6,3
    tv[3]  = '{32'h00815383, 32'h10C,  15, 32'h8,        0, 0, 0}; // LHU x7,8(x2)
    tv[4]  = '{32'h00208FA3, 32'h110,  16, 32'h1F,       0, 0, 0}; // SB
    tv[5]  = '{32'hFE20FCE3, 32'h114,  10, 32'hFFFFFFF8, 0, 0, 0}; // BGEU -8
    tv[6]  = '{32'h001000EF, 32'h2000,  3, 32'h800,      0, 1, 32'h2800}; // JAL x1,+0x800
    tv[7]  = '{32'hFFDFF06F, 32'h0,     3, 32'hFFFFFFFC, 0, 1, 32'hFFFFFFFC}; // JAL -4 at 0
    tv[8]  = '{32'h00000000, 32'h200,   0, 32'h0,        1, 0, 0}; // all-zero word
    tv[9]  = '{32'h023100B3, 32'h204,   0, 32'h0,        1, 0, 0}; // OP funct7=01
    tv[10] = '{32'h00000073, 32'h208,   0, 32'h0,        1, 0, 0}; // opcode 0x73
    tv[11] = '{32'h123452B7, 32'h20C,   1, 32'h12345000, 0, 0, 0}; // LUI
    tv[12] = '{32'h00001517, 32'h210,   2, 32'h1000,     0, 0, 0}; // AUIPC
    tv[13] = '{32'h004100E7, 32'h214,   4, 32'h4,        0, 0, 0}; // JALR
    tv[14] = '{32'h004110E7, 32'h218,   0, 32'h0,        1, 0, 0}; // JALR funct3=1
    tv[15] = '{32'h40111093, 32'h21C,   0, 32'h0,        1, 0, 0}; // SLLI bad funct7
    tv[16] = '{32'h80017093, 32'h220,  24, 32'hFFFFF800, 0, 0, 0}; // ANDI -2048
    tv[17] = '{32'hFE20AE23, 32'h224,  18, 32'hFFFFFFFC, 0, 0, 0}; // SW -4
    tv[18] = '{32'h00002063, 32'h228,   0, 32'h0,        1, 0, 0}; // branch funct3=2
    tv[19] = '{32'h403150B3, 32'h22C,  35, 32'h0,        0, 0, 0}; // SRA

    rst = 1'b1; flush = 1'b0; in_vld = 1'b0; in_inst = '0; in_pc = '0; out_rdy = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_out_vld", 64'(out_vld), 64'd0);
    chk("rst_in_rdy", 64'(in_rdy), 64'd1);
    chk("rst_fields", 64'({out_rs1, out_rs2, out_rd, out_instID, out_illegal}), 64'd0);
    chk("rst_imm", 64'(out_imm), 64'd0);
    chk("rst_pc", 64'(out_pc), 64'd0);
    chk("rst_jmp", 64'({jmp_vld, jmp_addr}), 64'd0);
    @(posedge clk); #1;

    // Back-to-back stream with EX always ready.
    out_rdy = 1'b1;
    for (int i = 0; i < 20; i++) send(tv[i]);
    drain();

    // Shuffled pass with random back-pressure and input bubbles.
    rand_rdy = 1'b1;
    for (int r = 0; r < 3; r++)
      for (int i = 0; i < 20; i++) begin
        if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
        send(tv[$urandom_range(0, 19)]);
      end
    rand_rdy = 1'b0;
    @(posedge clk); #1 out_rdy = 1'b1;
    drain();

    // Stall: two accepted, third (a JAL) refused without a redirect, then all drain in order.
    out_rdy = 1'b0;
    send(tv[1]);
    send(tv[2]);
    in_vld = 1'b1; in_inst = tv[6].inst; in_pc = tv[6].pc;
    @(negedge clk);
    chk("stall_in_rdy", 64'(in_rdy), 64'd0);
    chk("stall_no_jmp", 64'(jmp_vld), 64'd0);
    chk("stall_out_vld", 64'(out_vld), 64'd1);
    repeat (3) begin @(posedge clk); #1; end
    out_rdy = 1'b1;
    send(tv[6]);
    drain();

    // Flush with both entries held and a JAL presented in the flush cycle.
    out_rdy = 1'b0;
    send(tv[0]);
    send(tv[4]);
    in_vld = 1'b1; in_inst = tv[6].inst; in_pc = tv[6].pc; flush = 1'b1;
    @(negedge clk);
    chk("flush_no_jmp", 64'({jmp_vld, jmp_addr}), 64'd0);
    @(posedge clk); #1;
    flush = 1'b0; in_vld = 1'b0;
    sb.delete();
    @(negedge clk);
    chk("flush_out_vld", 64'(out_vld), 64'd0);
    chk("flush_in_rdy", 64'(in_rdy), 64'd1);
    @(posedge clk); #1 out_rdy = 1'b1;
    repeat (4) begin @(posedge clk); #1; end

    // Reset in the middle of a held stream.
    out_rdy = 1'b0;
    send(tv[5]);
    send(tv[11]);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    sb.delete();
    @(negedge clk);
    chk("midrst_out_vld", 64'(out_vld), 64'd0);
    chk("midrst_in_rdy", 64'(in_rdy), 64'd1);
    chk("midrst_imm_pc", 64'({out_imm, out_pc}), 64'd0);
    @(posedge clk); #1 out_rdy = 1'b1;
    send(tv[7]);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
